// File: rtl/arb_4_rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// hold-counter width and the debug view of internal state.
package arb_4_rr_pkg;

  localparam int HCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } state_t;

  typedef struct packed {
    state_t              state;
    logic [1:0]          ptr;
    logic [HCNT_W-1:0]   hcnt;
  } arb_dbg_t;

endpackage

// File: rtl/arb_4_rr_rr_pick_4.sv
// Combinational round-robin pick: first set request at or after ptr,
// scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic       w_found;
  logic [1:0] w_cand;

  always_comb begin
    any     = |req;
    idx     = ptr;
    w_found = 1'b0;
    w_cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      w_cand = ptr + 2'(k);
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_4_rr.sv
// Four-requester round-robin arbiter with hold limit; drives the select
// lines of the shared 4:1 mux and a one-hot grant back to the requesters.
module arb_4_rr
  import arb_4_rr_pkg::*;
#(
  parameter int HOLD_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] Select,
  output logic       busy,
  output logic       expired,
  output arb_dbg_t   dbg
);

  // Handshake: req[i] is a level that must stay high until grant[i] rises
  // (one cycle after sampling); the owner keeps the grant until it raises
  // done, drops req[i], or the hold limit forces release.

  localparam logic [HCNT_W-1:0] HL = HCNT_W'(HOLD_LIMIT);

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic [HCNT_W-1:0] r_hcnt;
  logic [3:0]        r_grant;
  logic [1:0]        r_select;
  logic              r_busy;
  logic              r_expired;

  logic              w_any;
  logic [1:0]        w_idx;
  logic              w_owner_req;
  logic              w_limit;
  logic              w_release;
  logic              w_expire;

  rr_pick_4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_owner_req = req[r_owner];
  assign w_limit     = (HL != '0) && (r_hcnt == HL);
  assign w_release   = done || !w_owner_req || w_limit;
  // Only a release caused purely by the limit counts as a forced expiry.
  assign w_expire    = w_limit && !done && w_owner_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_hcnt    <= '0;
      r_grant   <= 4'b0000;
      r_select  <= 2'b00;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_expired <= 1'b0;
          if (w_any) begin
            r_state  <= ST_GRANT;
            r_owner  <= w_idx;
            r_grant  <= 4'b0001 << w_idx;
            r_select <= w_idx;
            r_busy   <= 1'b1;
            r_hcnt   <= HCNT_W'(1);
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state   <= ST_IDLE;
            r_grant   <= 4'b0000;
            r_busy    <= 1'b0;
            r_ptr     <= r_owner + 2'd1;
            r_expired <= w_expire;
            r_hcnt    <= '0;
          end else if (r_hcnt != '1) begin
            r_hcnt <= r_hcnt + HCNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign Select    = r_select;
  assign busy      = r_busy;
  assign expired   = r_expired;
  assign dbg.state = r_state;
  assign dbg.ptr   = r_ptr;
  assign dbg.hcnt  = r_hcnt;

endmodule

// File: tb/tb_arb_4_rr.sv
// Directed bench for arb_4_rr: one instance with HOLD_LIMIT = 4 for the main
// scenarios, one with HOLD_LIMIT = 0 for the unlimited/saturating case.
module tb_arb_4_rr;
  import arb_4_rr_pkg::*;

  logic       clk;
  logic       reset, reset0;
  logic [3:0] req, req0;
  logic       done, done0;
  logic [3:0] grant, grant0;
  logic [1:0] sel, sel0;
  logic       busy, busy0;
  logic       expired, expired0;
  arb_dbg_t   dbg, dbg0;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;
  logic       seen_exp0;

  arb_4_rr #(.HOLD_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .Select(sel), .busy(busy), .expired(expired), .dbg(dbg)
  );

  arb_4_rr #(.HOLD_LIMIT(0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .done(done0),
    .grant(grant0), .Select(sel0), .busy(busy0), .expired(expired0), .dbg(dbg0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then sit 1 ns past it to sample and drive
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic e);
    check({tag, ".grant"},   32'(grant),   32'(g));
    check({tag, ".select"},  32'(sel),     32'(s));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".expired"}, 32'(expired), 32'(e));
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; done = 1'b0;
    reset0 = 1'b1; req0 = 4'b0000; done0 = 1'b0;
    tick(); tick();
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("reset.state", 32'(dbg.state), 32'(ST_IDLE));
    check("reset.ptr",   32'(dbg.ptr),   32'd0);
    check("reset.hcnt",  32'(dbg.hcnt),  32'd0);
    reset = 1'b0;

    // fairness: all request, done pulsed in every grant cycle
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_g = exp_q.pop_front();
      check_outs($sformatf("fair%0d", k), exp_g, 2'(k % 4), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_outs($sformatf("fair%0d.idle", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
    end
    check("fair.ptr", 32'(dbg.ptr), 32'd1);
    req = 4'b0000;
    tick();

    // single request, done release
    req = 4'b0100;
    tick();
    check_outs("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    check_outs("single.rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    check("single.ptr", 32'(dbg.ptr), 32'd3);

    // wrap-around: ptr 3, requesters 3 and 0
    req = 4'b1001;
    tick();
    check_outs("wrap.a", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("wrap.ptr", 32'(dbg.ptr), 32'd0);
    tick();
    check_outs("wrap.b", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    check("wrap.ptr2", 32'(dbg.ptr), 32'd1);

    // hold limit expiry on requester 0
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_outs($sformatf("hold.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      check($sformatf("hold.hcnt%0d", c), 32'(dbg.hcnt), 32'(c));
    end
    tick();
    check_outs("hold.expire", 4'b0000, 2'd0, 1'b0, 1'b1);
    check("hold.ptr", 32'(dbg.ptr), 32'd1);
    tick();
    check_outs("hold.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done coincident with the limit: normal release
    tick(); tick(); tick();
    check("sim.hcnt", 32'(dbg.hcnt), 32'd4);
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    check_outs("sim.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check("sim.noexp", 32'(expired), 32'd0);

    // owner drops request mid-grant
    req = 4'b0010;
    tick();
    check_outs("drop.g", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    req = 4'b0000;
    tick();
    check_outs("drop.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    check("drop.ptr", 32'(dbg.ptr), 32'd2);

    // reset during a grant with ptr = 2
    req = 4'b1111;
    tick();
    check_outs("rst.g", 4'b0100, 2'd2, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("rst.edge", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("rst.ptr", 32'(dbg.ptr), 32'd0);
    tick();
    check_outs("rst.first", 4'b0001, 2'd0, 1'b1, 1'b0);
    // others keep requesting; owner holds until the limit
    tick(); tick(); tick();
    check_outs("rst.hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    check_outs("rst.expire", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_outs("rst.next", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();

    // unlimited instance: hcnt saturates, no expiry
    reset0 = 1'b0; req0 = 4'b1000; seen_exp0 = 1'b0;
    tick();
    check("nolim.grant", 32'(grant0), 32'h8);
    check("nolim.sel",   32'(sel0),   32'd3);
    for (int c = 2; c <= 260; c++) begin
      tick();
      if (expired0 || grant0 != 4'b1000) seen_exp0 = 1'b1;
      if (c == 10) check("nolim.hcnt10", 32'(dbg0.hcnt), 32'd10);
    end
    check("nolim.held", 32'(seen_exp0), 32'd0);
    check("nolim.sat", 32'(dbg0.hcnt), 32'd255);
    req0 = 4'b0000;
    tick();
    check("nolim.rel", 32'(grant0), 32'h0);
    check("nolim.noexp", 32'(expired0), 32'd0);
    check("nolim.ptr", 32'(dbg0.ptr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
